iir_cascade_sched: RTL and testbench
====================================

// Module: iir_cascade_sched
// PURPOSE
//  Time-multiplexed scheduler for a cascade of biquad IIR sections. One shared 5-product
//  MAC datapath; per-section coefficient and state registers. Starts a run per audio sample.
//  Sits between the I2S receive path (x_in, lrclk_negedge) and the audio output mux.
//  Replaces one IIR instance per section; also owns runtime coefficient loading.
// PARAMETERS
//  N_SECT   4    number of biquad sections in the cascade (1..8)
//  DATA_W   16   sample width, signed
//  COEF_W   18   coefficient width, signed Q2.16
//  ACC_W    37   accumulator width, signed
//  FRAC     16   accumulator right-shift (arithmetic) to return to sample scale
// PORTS
//  clk            in   1        system clock
//  i_rst_n        in   1        synchronous active-low reset
//  lrclk_negedge  in   1        one-cycle sample strobe; starts a run
//  i_valid        in   1        0 = hold all filter state and output at zero
//  x_in           in   DATA_W   input sample; sampled on the accepted strobe
//  cfg_we         in   1        coefficient write strobe
//  cfg_sect       in   3        target section (0..N_SECT-1; writes >= N_SECT are ignored)
//  cfg_idx        in   3        0=b1 1=b2 2=b3 3=a2 4=a3; 5..7 ignored
//  cfg_data       in   COEF_W   coefficient; a2/a3 stored pre-negated (summed, not subtracted)
//  cfg_ready      out  1        1 when state==IDLE; cfg_we accepted only then
//  audio_out      out  DATA_W   output of last section, registered
//  o_out_valid    out  1        one-cycle pulse when audio_out updates
//  o_busy         out  1        1 while state==RUN
//  o_overrun      out  1        sticky; strobe arrived while busy
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge clk):
//   - state=IDLE; sec=0.
//   - All x1/x2/y1/y2 = 0.
//   - audio_out=0; o_out_valid=0; o_overrun=0.
//   - Coefficients per section: b1=65536 (1.0), others 0, i.e. passthrough.
//  FSM IDLE->RUN: in IDLE, lrclk_negedge & i_valid -> latch u=x_in, sec=0, go RUN.
//  FSM RUN: one section per cycle, sec = 0..N_SECT-1. In section s, with input u:
//   - acc = u*b1 + x1*b2 + x2*b3 + y1*a2 + y2*a3, computed at ACC_W, sign-extended.
//   - y = acc >>> FRAC, then narrowed to DATA_W (see CONFIGURATION).
//   - Update section s: x2<=x1, x1<=u, y2<=y1, y1<=y. Forward u<=y to the next section.
//  FSM RUN->IDLE: at sec==N_SECT-1, audio_out<=y, o_out_valid<=1 for one cycle, go IDLE.
//  Latency: strobe sampled at edge 0; audio_out/o_out_valid visible after edge N_SECT.
//   Max strobe rate is one per N_SECT+1 cycles.
//  Strobe in RUN: ignored (run continues unchanged); o_overrun<=1, cleared only by reset.
//  i_valid=0 (any state, including mid-run):
//   - Next edge: state=IDLE; all section state, audio_out and u cleared to 0.
//   - o_out_valid=0. Coefficients and o_overrun are kept.
//  cfg_we in IDLE: write lands at that edge. If a strobe arrives the same cycle, the run
//   sees the new coefficient. cfg_we while cfg_ready=0 is dropped silently.
//  Sync reset mid-run aborts the run; no o_out_valid is produced.
//  Sections are indexed by sec with wrap-free counting; sec never exceeds N_SECT-1.
// CONFIGURATION
//  IIR_SAT_EN defined:
//   - Each section's y saturates to [-32768, 32767] before storage and forwarding.
//  IIR_SAT_EN undefined:
//   - y = low DATA_W bits of (acc >>> FRAC); two's-complement wrap.
//   - Bit-exact with the legacy single-biquad path.
// TESTING
//  T1 reset, i_valid=1, x_in=1000, strobe -> o_out_valid after 4 cycles, audio_out=1000.
//  T2 cfg sect0 b1=32768; x_in=1000 -> audio_out=500; cfg_we while o_busy leaves b1 unchanged.
//  T3 sect0 b1=65536, a2=32768; strobes x=1000,0,0 -> audio_out 1000, 500, 250.
//  T4 sect0 b1=131071, x_in=30000 -> 32767 with IIR_SAT_EN; -5537 without.
//  T5 second strobe 2 cycles after first (N_SECT=4) -> ignored, o_overrun=1,
//     single o_out_valid carrying the first result.
//  T6 i_valid=0 at sec=2 -> no o_out_valid, audio_out=0; i_valid=1, x=1000 with T3 coefs -> 1000.

Source files
------------

// File: rtl/iir_cascade_sched_if.sv
// iir_cascade_sched_if: sample, coefficient-load and status signals of the biquad cascade scheduler
interface iir_cascade_sched_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18
);
    logic                     lrclk_negedge;
    logic                     i_valid;
    logic signed [DATA_W-1:0] x_in;
    logic                     cfg_we;
    logic [2:0]               cfg_sect;
    logic [2:0]               cfg_idx;
    logic signed [COEF_W-1:0] cfg_data;
    logic                     cfg_ready;
    logic signed [DATA_W-1:0] audio_out;
    logic                     o_out_valid;
    logic                     o_busy;
    logic                     o_overrun;

    modport master (
        output lrclk_negedge, i_valid, x_in, cfg_we, cfg_sect, cfg_idx, cfg_data,
        input  cfg_ready, audio_out, o_out_valid, o_busy, o_overrun
    );
    modport slave (
        input  lrclk_negedge, i_valid, x_in, cfg_we, cfg_sect, cfg_idx, cfg_data,
        output cfg_ready, audio_out, o_out_valid, o_busy, o_overrun
    );
endinterface

// File: rtl/iir_cascade_sched.sv
// iir_cascade_sched: time-multiplexed biquad cascade, one shared 5-product MAC, one section per cycle
// Define IIR_SAT_EN to saturate each section output; otherwise outputs wrap to DATA_W bits.
module iir_cascade_sched #(
    parameter int N_SECT = 4,
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int ACC_W  = 37,
    parameter int FRAC   = 16
) (
    input logic clk,
    input logic i_rst_n,
    iir_cascade_sched_if.slave bus
);
    localparam int SW = (N_SECT > 1) ? $clog2(N_SECT) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]               state;
    logic [SW-1:0]            sec;
    logic signed [COEF_W-1:0] coef [N_SECT][5];
    logic signed [DATA_W-1:0] x1 [N_SECT];
    logic signed [DATA_W-1:0] x2 [N_SECT];
    logic signed [DATA_W-1:0] y1 [N_SECT];
    logic signed [DATA_W-1:0] y2 [N_SECT];
    logic signed [DATA_W-1:0] u, y;
    logic signed [ACC_W-1:0]  acc, sh;
    logic                     last, cfg_ok;

    assign bus.cfg_ready = (state == IDLE);
    assign bus.o_busy    = (state == RUN);
    assign last          = (sec == SW'(N_SECT - 1));
    assign cfg_ok        = ({1'b0, bus.cfg_sect} < 4'(N_SECT)) && (bus.cfg_idx < 3'd5);

    always_comb begin
        acc = ACC_W'(u) * ACC_W'(coef[sec][0]) + ACC_W'(x1[sec]) * ACC_W'(coef[sec][1])
            + ACC_W'(x2[sec]) * ACC_W'(coef[sec][2]) + ACC_W'(y1[sec]) * ACC_W'(coef[sec][3])
            + ACC_W'(y2[sec]) * ACC_W'(coef[sec][4]);
        sh = acc >>> FRAC;
`ifdef IIR_SAT_EN
        y = (&sh[ACC_W-1:DATA_W-1] || ~|sh[ACC_W-1:DATA_W-1]) ? sh[DATA_W-1:0]
          : sh[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
        y = DATA_W'(sh);
`endif
    end

    // Coefficients survive i_valid drops; only reset restores passthrough.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            for (int s = 0; s < N_SECT; s++)
                for (int k = 0; k < 5; k++)
                    coef[s][k] <= (k == 0) ? COEF_W'(1 << FRAC) : COEF_W'(0);
        end else if (bus.cfg_we && bus.cfg_ready && cfg_ok) begin
            coef[bus.cfg_sect[SW-1:0]][bus.cfg_idx] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n || !bus.i_valid) begin
            state           <= IDLE;
            sec             <= '0;
            u               <= '0;
            bus.audio_out   <= '0;
            bus.o_out_valid <= 1'b0;
            for (int s = 0; s < N_SECT; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
            if (!i_rst_n) bus.o_overrun <= 1'b0;
        end else begin
            bus.o_out_valid <= 1'b0;
            if (state == IDLE) begin
                if (bus.lrclk_negedge) begin
                    u     <= bus.x_in;
                    sec   <= '0;
                    state <= RUN;
                end
            end else begin
                if (bus.lrclk_negedge) bus.o_overrun <= 1'b1;
                x2[sec] <= x1[sec];
                x1[sec] <= u;
                y2[sec] <= y1[sec];
                y1[sec] <= y;
                u       <= y;
                if (last) begin
                    bus.audio_out   <= y;
                    bus.o_out_valid <= 1'b1;
                    state           <= IDLE;
                    sec             <= '0;
                end else begin
                    sec <= sec + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_iir_cascade_sched.sv
// tb_iir_cascade_sched: randomized scoreboard bench against a whole-cascade arithmetic model
module tb_iir_cascade_sched;
    localparam int N = 4;

    logic clk = 1'b0;
    logic i_rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    longint exp_q[$];
    longint cb[N][5];
    longint mx1[N], mx2[N], my1[N], my2[N];

    iir_cascade_sched_if #(.DATA_W(16), .COEF_W(18)) bus ();
    iir_cascade_sched #(.N_SECT(N)) dut (.clk(clk), .i_rst_n(i_rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_clear_state();
        for (int s = 0; s < N; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endfunction

    function automatic void model_reset();
        model_clear_state();
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 5; k++) cb[s][k] = (k == 0) ? 65536 : 0;
    endfunction

    // Full cascade for one sample, each section a direct-form biquad
    function automatic longint model_run(longint x);
        longint u, acc, yv;
        u = x;
        for (int s = 0; s < N; s++) begin
            acc = u * cb[s][0] + mx1[s] * cb[s][1] + mx2[s] * cb[s][2]
                + my1[s] * cb[s][3] + my2[s] * cb[s][4];
            yv = acc >>> 16;
`ifdef IIR_SAT_EN
            yv = (yv > 32767) ? 32767 : (yv < -32768) ? -32768 : yv;
`else
            yv = longint'(shortint'(yv));
`endif
            mx2[s] = mx1[s]; mx1[s] = u; my2[s] = my1[s]; my1[s] = yv;
            u = yv;
        end
        return u;
    endfunction

    initial forever begin
        @(negedge clk);
        if (i_rst_n && bus.o_out_valid) begin
            if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
            else chk("audio_out", longint'(bus.audio_out), exp_q.pop_front());
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        bus.lrclk_negedge = 1'b0;
        bus.cfg_we = 1'b0;
        bus.i_valid = 1'b1;
        tick(2);
        i_rst_n = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    task automatic cfg(int s, int idx, int data, bit land);
        bus.cfg_we = 1'b1;
        bus.cfg_sect = 3'(s);
        bus.cfg_idx = 3'(idx);
        bus.cfg_data = 18'(data);
        tick(1);
        bus.cfg_we = 1'b0;
        if (land && s < N && idx < 5) cb[s][idx] = data;
    endtask

    task automatic strobe(int x, bit push);
        bus.lrclk_negedge = 1'b1;
        bus.x_in = 16'(x);
        tick(1);
        bus.lrclk_negedge = 1'b0;
        if (push) exp_q.push_back(model_run(x));
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain_timeout", exp_q.size(), 0);
        tick(1);
    endtask

    initial begin
        bus.lrclk_negedge = 1'b0; bus.i_valid = 1'b1; bus.x_in = '0;
        bus.cfg_we = 1'b0; bus.cfg_sect = '0; bus.cfg_idx = '0; bus.cfg_data = '0;
        do_reset();
        chk("rst_audio_out", longint'(bus.audio_out), 0);
        chk("rst_out_valid", bus.o_out_valid, 0);
        chk("rst_overrun", bus.o_overrun, 0);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_busy", bus.o_busy, 0);

        strobe(1000, 1);
        chk("busy_in_run", bus.o_busy, 1);
        chk("cfg_ready_in_run", bus.cfg_ready, 0);
        tick(N - 1);
        chk("valid_early", bus.o_out_valid, 0);
        tick(1);
        chk("valid_at_latency", bus.o_out_valid, 1);
        drain();

        cfg(0, 0, 32768, 1);
        strobe(1000, 1);
        cfg(0, 0, 0, 0);
        drain();
        strobe(1000, 1);
        drain();

        do_reset();
        cfg(0, 0, 65536, 1);
        cfg(0, 3, 32768, 1);
        for (int i = 0; i < 3; i++) begin
            strobe((i == 0) ? 1000 : 0, 1);
            drain();
        end

        do_reset();
        cfg(0, 0, 131071, 1);
        strobe(30000, 1);
        drain();

        do_reset();
        strobe(1000, 1);
        tick(1);
        strobe(2000, 0);
        chk("overrun_set", bus.o_overrun, 1);
        drain();
        tick(N + 2);
        chk("overrun_sticky", bus.o_overrun, 1);

        do_reset();
        cfg(0, 0, 65536, 1);
        cfg(0, 3, 32768, 1);
        strobe(1000, 1);
        drain();
        strobe(1000, 0);
        tick(2);
        bus.i_valid = 1'b0;
        tick(1);
        chk("abort_audio_out", longint'(bus.audio_out), 0);
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_out_valid", bus.o_out_valid, 0);
        tick(N + 1);
        bus.i_valid = 1'b1;
        model_clear_state();
        strobe(1000, 1);
        drain();
        strobe(0, 1);
        drain();
        chk("abort_overrun_kept", bus.o_overrun, 0);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int c = 0; c < 8; c++)
                cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 262143)) - 131072, 1);
            for (int i = 0; i < 12; i++) begin
                strobe(int'($urandom_range(0, 65535)) - 32768, 1);
                drain();
                tick(int'($urandom_range(0, 2)));
            end
        end

        tick(N + 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
